// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the interpolation gather/scatter paths.
package interp_pkg;

  localparam int DATA_W = 15;  // sample width, all lanes and the output word
  localparam int N_ROWS = 4;   // grid rows
  localparam int N_COLS = 2;   // grid columns
  localparam int BEATS  = 8;   // samples per block (N_ROWS * N_COLS)
  localparam int CNT_W  = 3;   // beat counter width
  localparam int ROW_W  = 2;   // row index width
  localparam int COL_W  = 1;   // column index width

  // Serializer control state: IDLE accepts a block, SEND drains it.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // True on the final beat of a block.
  function automatic logic is_last_beat(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/mux8_1_serializer_mux8_1.sv
// mux8_1: combinational 8:1 word select over a row-major 4x2 lane grid.
// Inverse of demux1_8; {row,col} picks lane index row*2+col.
module mux8_1
  import interp_pkg::*;
(
  input  logic [BEATS-1:0][DATA_W-1:0] lanes_i,
  input  logic [ROW_W-1:0]             row_i,
  input  logic                         col_i,
  output logic [DATA_W-1:0]            word_o
);

  logic [CNT_W-1:0]              sel;
  logic [BEATS-1:0][DATA_W-1:0]  masked;

  assign sel = {row_i, col_i};

  // One-hot gate each lane so the select is a flat AND-OR tree.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    assign masked[gi] = (sel == CNT_W'(gi)) ? lanes_i[gi] : '0;
  end

  // OR-reduce the gated lanes; at most one is non-zero.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      word_o = word_o | masked[i];
    end
  end

endmodule

// File: rtl/mux8_1_serializer.sv
// mux8_1_serializer: captures a 4x2 block of samples and streams it out one
// sample per beat in row-major order, with valid/ready on both sides.
module mux8_1_serializer
  import interp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in0_0,
  input  logic [DATA_W-1:0] in0_1,
  input  logic [DATA_W-1:0] in1_0,
  input  logic [DATA_W-1:0] in1_1,
  input  logic [DATA_W-1:0] in2_0,
  input  logic [DATA_W-1:0] in2_1,
  input  logic [DATA_W-1:0] in3_0,
  input  logic [DATA_W-1:0] in3_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_col,
  output logic              out_last
);

  state_t                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;
  logic [BEATS-1:0][DATA_W-1:0] buf_q;
  logic [BEATS-1:0][DATA_W-1:0] buf_d;
  logic [BEATS-1:0][DATA_W-1:0] lanes_w;
  logic [DATA_W-1:0]            word_w;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ROW_W-1:0]  out_row_q;
  logic              out_col_q;
  logic              out_last_q;

  logic last_beat;
  logic load;
  logic advance;
  logic done;

  // Lane grid flattened in beat order.
  assign lanes_w[0] = in0_0;
  assign lanes_w[1] = in0_1;
  assign lanes_w[2] = in1_0;
  assign lanes_w[3] = in1_1;
  assign lanes_w[4] = in2_0;
  assign lanes_w[5] = in2_1;
  assign lanes_w[6] = in3_0;
  assign lanes_w[7] = in3_1;

  // Upstream may load while idle, or in the same cycle the last beat drains,
  // which keeps back-to-back blocks gap-free.
  assign last_beat = is_last_beat(cnt_q);
  assign in_ready  = (state_q == IDLE) | ((state_q == SEND) & last_beat & out_ready);
  assign load      = in_valid & in_ready;
  assign advance   = (state_q == SEND) & out_ready & ~last_beat;
  assign done      = (state_q == SEND) & out_ready & last_beat;

  // Next buffer contents and beat index; the mux looks ahead at these so the
  // registered output word lines up with the registered counter.
  always_comb begin
    buf_d = load ? lanes_w : buf_q;
    cnt_d = cnt_q;
    if (load || done) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  mux8_1 u_mux (
    .lanes_i (buf_d),
    .row_i   (cnt_d[CNT_W-1:1]),
    .col_i   (cnt_d[0]),
    .word_o  (word_w)
  );

  // Control FSM, block buffer and registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      if (load || advance) begin
        state_q     <= SEND;
        out_valid_q <= 1'b1;
        out_data_q  <= word_w;
        out_row_q   <= cnt_d[CNT_W-1:1];
        out_col_q   <= cnt_d[0];
        out_last_q  <= is_last_beat(cnt_d);
      end else if (done) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux8_1_serializer.sv
// Scoreboard bench for mux8_1_serializer: the driver pushes expected beats when a
// block loads, the monitor pops and compares on every consumed output beat.
module tb_mux8_1_serializer;
  import interp_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic              out_col;
  logic              out_last;
  logic [DATA_W-1:0] lane [8];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        row;
    logic              col;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    mode   = 0;  // 0: out_ready=1, 1: 1,0,0,1 pattern

  mux8_1_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0_0     (lane[0]),
    .in0_1     (lane[1]),
    .in1_0     (lane[2]),
    .in1_1     (lane[3]),
    .in2_0     (lane[4]),
    .in2_1     (lane[5]),
    .in3_0     (lane[6]),
    .in3_1     (lane[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Downstream ready generator, changes just after each rising edge.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        out_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: stall stability plus scoreboard compare on each consumed beat.
  initial begin
    beat_t prev = '0;
    beat_t got;
    beat_t e;
    bit    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      got = '{data: out_data, row: out_row, col: out_col, last: out_last};
      if (prev_stall) begin
        check("stall_hold", {out_valid, got}, {1'b1, prev});
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev = got;
      if (out_valid && out_ready && !rst) begin
        $display("beat data=%h row=%0d col=%0d last=%0d", out_data, out_row, out_col, out_last);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got %h with no beat expected", got);
        end else begin
          e = exp_q.pop_front();
          check("beat", got, e);
        end
      end
    end
  end

  // Present a block, wait (bounded) for acceptance, queue its 8 expected beats.
  task automatic send_block(input logic [DATA_W-1:0] v[8], input bit hold, input bit scramble);
    int n = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 8; i++) lane[i] = v[i];
    in_valid = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got in_ready=0 for 300 cycles required 1");
    end else begin
      $display("load block lane0=%h lane7=%h", v[0], v[7]);
      for (int i = 0; i < 8; i++)
        exp_q.push_back('{data: v[i], row: 2'(i / 2), col: 1'(i % 2), last: (i == 7)});
    end
    @(posedge clk);
    #1;
    if (scramble) for (int i = 0; i < 8; i++) lane[i] = 15'h5A5A ^ 15'(i);
    if (!hold) in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat is consumed and the DUT is idle.
  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 400);
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] v[8];
    logic [DATA_W-1:0] w[8];
    int n;
    for (int i = 0; i < 8; i++) lane[i] = '0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_last", out_last, 0);
    check("rst_out_rowcol", {out_row, out_col}, 0);
    @(posedge clk);
    #1;

    // 2: single block 0x100..0x107
    for (int i = 0; i < 8; i++) v[i] = 15'h100 + 15'(i);
    send_block(v, 1'b0, 1'b0);
    wait_drain();
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    // 3: backpressure, lanes scrambled after the load edge
    mode = 1;
    for (int i = 0; i < 8; i++) v[i] = 15'h200 + 15'(i);
    send_block(v, 1'b0, 1'b1);
    wait_drain();
    mode = 0;

    // 4: back-to-back blocks, no gap, in_ready only on last beats
    for (int i = 0; i < 8; i++) v[i] = 15'(i);
    for (int i = 0; i < 8; i++) w[i] = 15'h7FF - 15'(i);
    fork
      begin
        send_block(v, 1'b1, 1'b0);
        send_block(w, 1'b0, 1'b0);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 100);
        for (int i = 0; i < 16; i++) begin
          if (i > 0) @(negedge clk);
          check("b2b_valid", out_valid, 1);
          check("b2b_in_ready", in_ready, 32'((i % 8) == 7));
        end
      end
    join
    wait_drain();

    // 5: reset while beat 4 is presented, then a fresh block
    for (int i = 0; i < 8; i++) v[i] = 15'h300 + 15'(i);
    send_block(v, 1'b0, 1'b0);
    n = 0;
    while (!(out_valid && out_row == 2'd2 && !out_col) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat4_reached", out_valid && out_row == 2'd2 && !out_col, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) v[i] = 15'h400 + 15'(i);
    send_block(v, 1'b0, 1'b0);
    wait_drain();

    // 6: full-scale samples
    for (int i = 0; i < 8; i++) v[i] = 15'h7FFF;
    send_block(v, 1'b0, 1'b0);
    wait_drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
